// File: rtl/sfpga_load_pkg.sv
// Shared encodings and timer helper for the slave-FPGA configuration supervisor.
package sfpga_load_pkg;

  localparam int TIMER_W = 26;

  typedef logic [TIMER_W-1:0] timer_t;

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    PREFILL,
    KICK,
    WAIT_INIT,
    LOADING,
    RETRY_WAIT,
    DONE,
    FAIL
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_INIT_TO = 3'd1,
    FC_LOAD_TO = 3'd2,
    FC_CRC     = 3'd3,
    FC_SRC_ERR = 3'd4,
    FC_ABORT   = 3'd5
  } fail_code_e;

  // A timed state lasts exactly n cycles when its down-counter starts at n-1.
  function automatic timer_t cycles_to_timer(input int unsigned n);
    return (n == 0) ? '0 : timer_t'(n - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sfpga_load_ctrl.sv
// Supervisor for one slave-FPGA SelectMAP load: flush, prefill, kick the driver,
// watch INIT_B/DONE against timeouts, retry, and report sticky status.
module sfpga_load_ctrl
  import sfpga_load_pkg::*;
#(
  parameter int unsigned LEVEL_W     = 12,
  parameter int unsigned PREFILL_LVL = 256,
  parameter int unsigned FLUSH_CYC   = 16,
  parameter int unsigned INIT_TO     = 50_000,
  parameter int unsigned LOAD_TO     = 50_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start_i,
  input  logic               load_abort_i,
  input  logic [LEVEL_W-1:0] fifo_level_i,
  input  logic               cfg_load_last_i,
  input  logic               src_err_i,
  input  logic               sfpga_init_b_i,
  input  logic               sfpga_done_i,
  output logic               fifo_rst_o,
  output logic               img_req_o,
  output logic               cfg_fifo_ready_o,
  output logic               load_busy_o,
  output logic               load_done_o,
  output logic               load_fail_o,
  output logic [2:0]         fail_code_o,
  output logic [3:0]         retry_cnt_o
);

  localparam logic [LEVEL_W-1:0] PREFILL_THR = LEVEL_W'(PREFILL_LVL);
  localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRY);

  state_e     state, state_nxt;
  timer_t     timer;
  fail_code_e cause, cause_nxt;
  logic       init_s, done_s;
  logic       lvl_ok, last_seen, init_low_seen;
  logic       fail_ev, abort_ev, start_clr;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_init (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sfpga_init_b_i),
    .q     (init_s)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_done (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sfpga_done_i),
    .q     (done_s)
  );

  assign abort_ev  = load_abort_i && (state != IDLE);
  assign start_clr = (state == IDLE) && (state_nxt == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fail_ev   = 1'b0;
    cause_nxt = FC_NONE;
    case (state)
      IDLE:       if (load_start_i) state_nxt = FLUSH;
      FLUSH:      if (timer == '0) state_nxt = PREFILL;
      PREFILL:    if (lvl_ok || last_seen) state_nxt = KICK;
      KICK:       state_nxt = WAIT_INIT;
      WAIT_INIT: begin
        if (init_low_seen && init_s) begin
          state_nxt = LOADING;
        end else if (timer == '0) begin
          fail_ev   = 1'b1;
          cause_nxt = FC_INIT_TO;
        end
      end
      // DONE wins over a simultaneous INIT_B low: the device finished.
      LOADING: begin
        if (done_s) begin
          state_nxt = DONE;
        end else if (!init_s) begin
          fail_ev   = 1'b1;
          cause_nxt = FC_CRC;
        end else if (src_err_i) begin
          fail_ev   = 1'b1;
          cause_nxt = FC_SRC_ERR;
        end else if (timer == '0) begin
          fail_ev   = 1'b1;
          cause_nxt = FC_LOAD_TO;
        end
      end
      RETRY_WAIT: if (timer == '0) state_nxt = FLUSH;
      DONE:       state_nxt = IDLE;
      FAIL:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (fail_ev) state_nxt = (retry_cnt_o < RETRY_MAX) ? RETRY_WAIT : FAIL;
    if (abort_ev) begin
      state_nxt = FAIL;
      cause_nxt = FC_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer            <= '0;
      cause            <= FC_NONE;
      lvl_ok           <= 1'b0;
      last_seen        <= 1'b0;
      init_low_seen    <= 1'b0;
      fifo_rst_o       <= 1'b0;
      img_req_o        <= 1'b0;
      cfg_fifo_ready_o <= 1'b0;
      load_busy_o      <= 1'b0;
      load_done_o      <= 1'b0;
      load_fail_o      <= 1'b0;
      fail_code_o      <= 3'd0;
      retry_cnt_o      <= 4'd0;
    end else begin
      lvl_ok <= (fifo_level_i >= PREFILL_THR);

      if (state_nxt != state) begin
        case (state_nxt)
          FLUSH:      timer <= cycles_to_timer(FLUSH_CYC);
          WAIT_INIT:  timer <= cycles_to_timer(INIT_TO);
          LOADING:    timer <= cycles_to_timer(LOAD_TO);
          RETRY_WAIT: timer <= cycles_to_timer(RETRY_GAP);
          default:    timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - timer_t'(1);
      end

      if ((state_nxt == FLUSH) && (state != FLUSH)) last_seen <= 1'b0;
      else if (cfg_load_last_i)                     last_seen <= 1'b1;

      if (state == KICK)                      init_low_seen <= 1'b0;
      else if ((state == WAIT_INIT) && !init_s) init_low_seen <= 1'b1;

      if (fail_ev || abort_ev) cause <= cause_nxt;

      // Outputs are decoded from the next state so they line up with it.
      fifo_rst_o       <= (state_nxt == FLUSH);
      img_req_o        <= (state_nxt inside {PREFILL, KICK, WAIT_INIT, LOADING});
      cfg_fifo_ready_o <= (state_nxt == KICK);
      load_busy_o      <= (state_nxt != IDLE);

      if (start_clr) begin
        load_done_o <= 1'b0;
        load_fail_o <= 1'b0;
        fail_code_o <= 3'd0;
        retry_cnt_o <= 4'd0;
      end else begin
        if (fail_ev && !abort_ev && (retry_cnt_o < RETRY_MAX)) retry_cnt_o <= retry_cnt_o + 4'd1;
        if ((state == DONE) && (state_nxt == IDLE)) load_done_o <= 1'b1;
        if (state == FAIL) begin
          load_fail_o <= 1'b1;
          fail_code_o <= cause;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfpga_load_ctrl.sv
// Directed bench for sfpga_load_ctrl with an end-of-load scoreboard and latency checks.
module tb_sfpga_load_ctrl;

  localparam int LEVEL_W = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_start_i, load_abort_i, cfg_load_last_i, src_err_i;
  logic [LEVEL_W-1:0] fifo_level_i;
  logic               sfpga_init_b_i, sfpga_done_i;
  logic               fifo_rst_o, img_req_o, cfg_fifo_ready_o, load_busy_o;
  logic               load_done_o, load_fail_o;
  logic [2:0]         fail_code_o;
  logic [3:0]         retry_cnt_o;

  typedef struct packed {
    logic       done;
    logic       fail;
    logic [2:0] code;
    logic [3:0] retry;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests, n_fail;
  int   cyc;
  int   kick_cnt, flush_n, run;
  int   flush_len [0:63];
  int   t0, k0, k1, k2, kb, fb;

  sfpga_load_ctrl #(
    .LEVEL_W     (LEVEL_W),
    .PREFILL_LVL (8),
    .FLUSH_CYC   (16),
    .INIT_TO     (100),
    .LOAD_TO     (1000),
    .MAX_RETRY   (2),
    .RETRY_GAP   (200)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_start_i     (load_start_i),
    .load_abort_i     (load_abort_i),
    .fifo_level_i     (fifo_level_i),
    .cfg_load_last_i  (cfg_load_last_i),
    .src_err_i        (src_err_i),
    .sfpga_init_b_i   (sfpga_init_b_i),
    .sfpga_done_i     (sfpga_done_i),
    .fifo_rst_o       (fifo_rst_o),
    .img_req_o        (img_req_o),
    .cfg_fifo_ready_o (cfg_fifo_ready_o),
    .load_busy_o      (load_busy_o),
    .load_done_o      (load_done_o),
    .load_fail_o      (load_fail_o),
    .fail_code_o      (fail_code_o),
    .retry_cnt_o      (retry_cnt_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Kick pulses and flush pulse lengths, sampled on the falling edge.
  always @(negedge clk) begin
    if (cfg_fifo_ready_o) kick_cnt <= kick_cnt + 1;
    if (fifo_rst_o) begin
      run <= run + 1;
    end else if (run != 0) begin
      if (flush_n < 64) flush_len[flush_n] <= run;
      flush_n <= flush_n + 1;
      run     <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 img_req high, 1 img_req low, 2 load_done high, 3 busy low, 4 kick pulse
  task automatic wait_for(input int sel, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (img_req_o === 1'b1);
        1:       hit = (img_req_o === 1'b0);
        2:       hit = (load_done_o === 1'b1);
        3:       hit = (load_busy_o === 1'b0);
        4:       hit = (cfg_fifo_ready_o === 1'b1);
        default: hit = 1'b0;
      endcase
    end
    n_tests++;
    assert (hit === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: event not seen within %0d cycles (observed 0 expected 1)", tag, budget);
    end
  endtask

  task automatic pulse_start();
    step(1);
    load_start_i = 1'b1;
    step(1);
    load_start_i = 1'b0;
  endtask

  task automatic handshake(input string tag);
    wait_for(4, 3000, {tag, "_kick"});
    step(5);
    sfpga_init_b_i = 1'b0;
    step(20);
    sfpga_init_b_i = 1'b1;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    wait_for(3, 5000, {tag, "_end"});
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_done"},  32'(load_done_o), 32'(e.done));
      check({tag, "_fail"},  32'(load_fail_o), 32'(e.fail));
      check({tag, "_code"},  32'(fail_code_o), 32'(e.code));
      check({tag, "_retry"}, 32'(retry_cnt_o), 32'(e.retry));
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({fifo_rst_o, img_req_o, cfg_fifo_ready_o, load_busy_o,
                load_done_o, load_fail_o, fail_code_o, retry_cnt_o});
  endfunction

  initial begin
    rst_n           = 1'b1;
    load_start_i    = 1'b0;
    load_abort_i    = 1'b0;
    cfg_load_last_i = 1'b0;
    src_err_i       = 1'b0;
    fifo_level_i    = '0;
    sfpga_init_b_i  = 1'b1;
    sfpga_done_i    = 1'b0;
    #3 rst_n = 1'b0;
    step(3);
    check("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Nominal load with a level ramp
    sb_q.push_back('{done: 1'b1, fail: 1'b0, code: 3'd0, retry: 4'd0});
    kb = kick_cnt; fb = flush_n;
    pulse_start();
    check("start_fifo_rst", 32'(fifo_rst_o), 32'd1);
    check("start_busy", 32'(load_busy_o), 32'd1);
    wait_for(0, 100, "nom_req");
    for (int l = 1; l <= 8; l++) begin
      step(1);
      fifo_level_i = LEVEL_W'(l);
    end
    t0 = cyc;
    wait_for(4, 20, "nom_kick");
    check("level_to_kick", 32'(cyc - t0), 32'd2);
    step(5);
    sfpga_init_b_i = 1'b0;
    step(20);
    sfpga_init_b_i = 1'b1;
    step(500);
    sfpga_done_i = 1'b1;
    t0 = cyc;
    wait_for(2, 20, "nom_done_rise");
    check("done_pin_to_flag", 32'(cyc - t0), 32'd4);
    sb_check("nom");
    check("nom_kicks", 32'(kick_cnt - kb), 32'd1);
    check("nom_flush_len", 32'(flush_len[fb]), 32'd16);
    sfpga_done_i = 1'b0;
    step(5);

    // INIT_B never moves: three kicks then init timeout
    sb_q.push_back('{done: 1'b0, fail: 1'b1, code: 3'd1, retry: 4'd2});
    kb = kick_cnt; fb = flush_n;
    pulse_start();
    wait_for(4, 100, "ito_kick0");
    k0 = cyc;
    repeat (150) @(negedge clk);
    check("retry_gap_req", 32'(img_req_o), 32'd0);
    check("retry_gap_busy", 32'(load_busy_o), 32'd1);
    wait_for(4, 1000, "ito_kick1");
    k1 = cyc;
    wait_for(4, 1000, "ito_kick2");
    k2 = cyc;
    check("kick_period_1", 32'(k1 - k0), 32'd318);
    check("kick_period_2", 32'(k2 - k1), 32'd318);
    sb_check("ito");
    check("ito_kicks", 32'(kick_cnt - kb), 32'd3);
    check("ito_flushes", 32'(flush_n - fb), 32'd3);

    // CRC on the first attempt, success on the second
    sb_q.push_back('{done: 1'b1, fail: 1'b0, code: 3'd0, retry: 4'd1});
    kb = kick_cnt; fb = flush_n;
    pulse_start();
    handshake("crc0");
    step(10);
    sfpga_init_b_i = 1'b0;
    t0 = cyc;
    wait_for(1, 20, "crc_req_drop");
    check("init_pin_to_action", 32'(cyc - t0), 32'd3);
    step(1);
    sfpga_init_b_i = 1'b1;
    handshake("crc1");
    step(50);
    sfpga_done_i = 1'b1;
    sb_check("crc");
    check("crc_kicks", 32'(kick_cnt - kb), 32'd2);
    check("crc_flushes", 32'(flush_n - fb), 32'd2);
    check("crc_flush_len0", 32'(flush_len[fb]), 32'd16);
    check("crc_flush_len1", 32'(flush_len[fb+1]), 32'd16);
    sfpga_done_i = 1'b0;
    fifo_level_i = '0;
    step(5);

    // Abort while waiting for prefill
    sb_q.push_back('{done: 1'b0, fail: 1'b1, code: 3'd5, retry: 4'd0});
    kb = kick_cnt;
    pulse_start();
    wait_for(0, 100, "abp_req");
    step(1);
    load_abort_i = 1'b1;
    step(1);
    load_abort_i = 1'b0;
    check("abort_prefill_req", 32'(img_req_o), 32'd0);
    sb_check("abp");
    check("abp_kicks", 32'(kick_cnt - kb), 32'd0);
    fifo_level_i = LEVEL_W'(8);
    step(5);

    // Abort in the same cycle DONE is seen
    sb_q.push_back('{done: 1'b0, fail: 1'b1, code: 3'd5, retry: 4'd0});
    kb = kick_cnt;
    pulse_start();
    handshake("abd");
    step(10);
    sfpga_done_i = 1'b1;
    step(2);
    load_abort_i = 1'b1;
    step(1);
    load_abort_i = 1'b0;
    check("abort_done_req", 32'(img_req_o), 32'd0);
    sb_check("abd");
    check("abd_kicks", 32'(kick_cnt - kb), 32'd1);
    sfpga_done_i = 1'b0;
    step(5);

    // Load timeout on every attempt, with a start pulse ignored mid-load
    sb_q.push_back('{done: 1'b0, fail: 1'b1, code: 3'd2, retry: 4'd2});
    fb = flush_n;
    pulse_start();
    handshake("lto0");
    t0 = cyc;
    step(100);
    load_start_i = 1'b1;
    step(1);
    load_start_i = 1'b0;
    check("busy_start_flush", 32'(fifo_rst_o), 32'd0);
    check("busy_start_busy", 32'(load_busy_o), 32'd1);
    check("busy_start_retry", 32'(retry_cnt_o), 32'd0);
    wait_for(1, 1500, "lto_req_drop");
    check("load_timeout_len", 32'(cyc - t0), 32'd1003);
    handshake("lto1");
    handshake("lto2");
    sb_check("lto");
    check("lto_flushes", 32'(flush_n - fb), 32'd3);
    step(5);

    // Reset during LOADING, then a clean attempt
    pulse_start();
    handshake("rst0");
    step(10);
    check("pre_reset_busy", 32'(load_busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    sb_q.push_back('{done: 1'b1, fail: 1'b0, code: 3'd0, retry: 4'd0});
    kb = kick_cnt;
    pulse_start();
    handshake("rst1");
    step(30);
    sfpga_done_i = 1'b1;
    sb_check("rst");
    check("rst_kicks", 32'(kick_cnt - kb), 32'd1);
    sfpga_done_i = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
